rr_wr_arbiter: RTL and testbench

RR_WR_ARBITER -- requirements
Module: rr_wr_arbiter

---
 rtl/rr_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up
// to MAX_BURST beats into a downstream FIFO, with a one-cycle IDLE bubble.
module rr_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int OW        = $clog2(NUM_REQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ack,
    input  logic                          i_full,
    output logic                          o_wren,
    output logic [DATA_WIDTH-1:0]         o_wdata,
    output logic                          o_busy,
    output logic [OW-1:0]                 o_owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [OW-1:0]   pick;
    logic            pick_vld;
    logic [OW-1:0]   owner_inc;
    logic            owner_req;
    logic [DATA_WIDTH-1:0] owner_data;
    logic            beat;
    logic            last;

    // Search ptr, ptr+1, ... ; scan downward so the smallest offset wins.
    always_comb begin
        logic [OW-1:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = OW'((int'(ptr_q) + i) % NUM_REQ);
            if (i_req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == OW'(k)) begin
                owner_req  = i_req[k];
                owner_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_inc = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign beat      = (state_q == BURST) && owner_req && !i_full;
    assign last      = (cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        o_ack   = '0;
        o_wren  = 1'b0;
        o_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    ptr_d   = owner_inc;
                end else if (beat) begin
                    o_wren  = 1'b1;
                    o_wdata = owner_data;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        o_ack[k] = (owner_q == OW'(k));
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        ptr_d   = owner_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_busy  = (state_q == BURST);
    assign o_owner = owner_q;

endmodule

// File: tb/tb_rr_wr_arbiter.sv
// Scoreboard bench for rr_wr_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural arbitration model.
module tb_rr_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int OW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*DW-1:0]  data = '0;
    logic              full = 1'b0;
    logic [NR-1:0]     ack;
    logic              wren;
    logic [DW-1:0]     wdata;
    logic              busy;
    logic [OW-1:0]     owner;

    rr_wr_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_req  (req),
        .i_data (data),
        .o_ack  (ack),
        .i_full (full),
        .o_wren (wren),
        .o_wdata(wdata),
        .o_busy (busy),
        .o_owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wren;
        logic [NR-1:0] ack;
        logic [DW-1:0] wdata;
        logic          busy;
        logic [OW-1:0] owner;
    } exp_t;

    exp_t              cq[$];
    logic [OW+DW-1:0]  wq[$];
    int                starts[$];
    int                checks = 0;
    int                passes = 0;
    int                wr_total = 0;
    int                base;
    logic              prev_busy = 1'b0;
    exp_t              mon_e;
    logic [OW+DW-1:0]  mon_w;

    // Model: who holds the grant, beats done, where the next search starts.
    int m_busy, m_owner, m_beats, m_ptr;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
    endtask

    // Called at a falling edge: drive one cycle, predict it, wait a cycle.
    task automatic step(logic [NR-1:0] r, logic f);
        exp_t e;
        logic [DW-1:0] d;
        req  = r;
        full = f;
        for (int k = 0; k < NR; k++) data[k*DW +: DW] = DW'($urandom);
        e       = '0;
        e.owner = OW'(m_owner);
        e.busy  = (m_busy != 0);
        if (m_busy == 0) begin
            if (r != '0) begin
                for (int i = 0; i < NR; i++) begin
                    if (r[(m_ptr + i) % NR]) begin
                        m_owner = (m_ptr + i) % NR;
                        break;
                    end
                end
                m_busy  = 1;
                m_beats = 0;
            end
        end else if (r[m_owner] && !f) begin
            d       = data[m_owner*DW +: DW];
            e.wren  = 1'b1;
            e.ack   = NR'(1) << m_owner;
            e.wdata = d;
            wq.push_back({OW'(m_owner), d});
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % NR;
            end
        end else if (!r[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NR;
        end
        cq.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        full  = 1'b0;
        #1;
        check("reset_outputs", {wren, ack, wdata, busy, owner}, 64'd0);
        model_reset();
        cq.delete();
        wq.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every predicted cycle, and every write against wq.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (cq.size() > 0) begin
                mon_e = cq.pop_front();
                check("cycle", {wren, ack, wdata, busy, owner}, 64'(mon_e));
            end
            if (wren) begin
                wr_total++;
                if (wq.size() == 0) begin
                    checks++;
                    $display("FAIL write_unexpected: got owner %0d data %0h expected no write",
                             owner, wdata);
                end else begin
                    mon_w = wq.pop_front();
                    check("wdata", {owner, wdata}, 64'(mon_w));
                end
            end
            if (busy && !prev_busy) starts.push_back(int'(owner));
            prev_busy = busy;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // all four requesting continuously
        starts.delete();
        base = wr_total;
        repeat (20) step(4'b1111, 1'b0);
        check("fair_writes", 64'(wr_total - base), 64'd16);
        check("fair_bursts", 64'(starts.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fair_order%0d", i),
                  64'(starts.size() > i ? starts[i] : -1), 64'(i));
        end
        repeat (2) step(4'b1111, 1'b0);
        check("fair_order4", 64'(starts.size() > 4 ? starts[4] : -1), 64'd0);

        // full stall on requester 2
        do_reset();
        base = wr_total;
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        repeat (3) step(4'b0100, 1'b1);
        check("stall_held", 64'(wr_total - base), 64'd1);
        repeat (3) step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        check("stall_beats", 64'(wr_total - base), 64'd4);

        // early drop by requester 1 with 3 pending
        do_reset();
        base = wr_total;
        repeat (3) step(4'b1010, 1'b0);
        step(4'b1000, 1'b0);
        check("drop_idle", 64'(busy), 64'd0);
        step(4'b1000, 1'b0);
        check("drop_owner3", 64'({busy, owner}), 64'({1'b1, 2'd3}));
        check("drop_writes", 64'(wr_total - base), 64'd2);
        repeat (5) step(4'b1000, 1'b0);

        // wrap from ptr=3 and a single persistent requester
        do_reset();
        repeat (5) step(4'b0100, 1'b0);
        step(4'b0001, 1'b0);
        check("wrap_owner0", 64'({busy, owner}), 64'({1'b1, 2'd0}));
        base = wr_total;
        repeat (10) step(4'b0001, 1'b0);
        check("single_writes", 64'(wr_total - base), 64'd8);

        // reset in the middle of a burst by requester 2
        do_reset();
        repeat (3) step(4'b0100, 1'b0);
        #1;
        check("mid_wren_before", 64'(wren), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wren", 64'(wren), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        model_reset();
        cq.delete();
        wq.delete();
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110, 1'b0);
        check("mid_regrant", 64'({busy, owner}), 64'({1'b1, 2'd1}));
        repeat (6) step(4'b0110, 1'b0);

        // random traffic with occasional resets
        do_reset();
        repeat (600) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            step(NR'($urandom), ($urandom_range(0, 3) == 0));
        end
        step(4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
